pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of performance counters.
REQ-002 SHALL have parameter DMEM_TIMEOUT, default 64, maximum data-memory wait cycles before bus error.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports i_if_stall, i_id_stall, i_id_flush, i_ie_flush  input  1 each  stall/flush requests from the hazard unit.
REQ-006 SHALL have port i_imem_ready  input  1  instruction memory has valid fetch data this cycle.
REQ-007 SHALL have ports i_dmem_req  input  1 (memory stage issues a load/store) and i_dmem_ack  input  1 (access completes this cycle).
REQ-008 SHALL have port i_cnt_clr  input  1  synchronous clear of both counters.
REQ-009 SHALL have ports o_pc_en, o_ifid_en, o_idie_en, o_iem_en, o_mwb_en  output  1 each  pipeline register load enables.
REQ-010 SHALL have ports o_ifid_clr, o_idie_clr  output  1 each  bubble insertion (register loads NOP) when its enable is also high.
REQ-011 SHALL have port o_bus_err  output  1  one-cycle pulse on data-memory timeout.
REQ-012 SHALL have port o_state  output  2  FSM state: 00 RUN, 01 DWAIT, 10 DERR.
REQ-013 SHALL have ports o_stall_cnt, o_flush_cnt  output  CNT_WIDTH each  performance counters.

Function
REQ-014 SHALL implement three states: RUN, DWAIT, DERR; encoding 11 unreachable and, if entered, returns to RUN next cycle.
REQ-015 RUN, i_dmem_req=1 and i_dmem_ack=0: all five enables 0, both clears 0; next state DWAIT; wait counter loaded with 1.
REQ-016 RUN otherwise: o_pc_en = i_id_flush | (~i_if_stall & i_imem_ready); o_ifid_en = i_id_flush | ~i_id_stall; o_ifid_clr = i_id_flush | ~i_imem_ready; o_idie_en=o_iem_en=o_mwb_en=1; o_idie_clr = i_ie_flush.
REQ-017 Priority in RUN: dmem wait > flush > load-use stall > imem not ready.
REQ-018 DWAIT, i_dmem_ack=0 and wait counter < DMEM_TIMEOUT: all enables 0, counter increments; stay DWAIT.
REQ-019 DWAIT, i_dmem_ack=1: outputs per REQ-016 this cycle, with i_id_flush/i_ie_flush replaced by their OR with the pending-flush register; next state RUN; pending-flush cleared.
REQ-020 DWAIT, counter = DMEM_TIMEOUT and no ack: next state DERR, all enables 0.
REQ-021 DERR: o_bus_err=1 for exactly one cycle; outputs as REQ-019 (access abandoned, pipeline resumes); next state RUN.
REQ-022 A flush request (i_id_flush or i_ie_flush) seen in DWAIT SHALL set the pending-flush register; it is never lost.
REQ-023 i_dmem_ack in RUN without req, or ack coincident with req: no wait, RUN outputs per REQ-016.
REQ-024 o_stall_cnt SHALL increment by 1 each cycle o_pc_en=0 while reset is deasserted; saturates at all ones.
REQ-025 o_flush_cnt SHALL increment by 1 each cycle an id flush is applied (REQ-016/019/021); saturates at all ones.
REQ-026 i_cnt_clr=1 SHALL zero both counters next edge, overriding increment.
REQ-027 All outputs except counters, o_state, o_bus_err SHALL be combinational from state and inputs; no added latency.

Reset
REQ-028 While i_rst_n=0 at a clock edge: state RUN, wait counter 0, pending-flush 0, counters 0.
REQ-029 While i_rst_n=0: all enables 0, both clears 1, o_bus_err 0, regardless of state or inputs.
REQ-030 Reset asserted in DWAIT or DERR SHALL abandon the access; RUN after deassertion, no o_bus_err.

Verification
REQ-031 Load-use: RUN, i_if_stall=i_id_stall=i_ie_flush=1 -> pc_en=0, ifid_en=0, idie_clr=1; stall_cnt +1.
REQ-032 Branch: i_id_flush=i_ie_flush=1, i_imem_ready=0 -> pc_en=1, ifid_clr=1, idie_clr=1; flush_cnt +1.
REQ-033 Dmem wait: req=1 ack=0 for 3 cycles then ack=1 -> state 01 for 3 cycles, all enables 0, RUN after ack; stall_cnt +4.
REQ-034 Flush during wait: i_id_flush pulsed in DWAIT cycle 2, ack in cycle 5 -> ifid_clr=1 and pc_en=1 on ack cycle.
REQ-035 Timeout: DMEM_TIMEOUT=4, ack never -> DERR after 4 wait cycles, o_bus_err one pulse, then RUN.
REQ-036 Saturation/clear: CNT_WIDTH=4, 20 stall cycles -> o_stall_cnt=15; i_cnt_clr=1 -> 0 next cycle.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline register enable/bubble controller: merges hazard-unit stall/flush
// requests with data-memory wait handling, a bus-error timeout and perf counters.
module pipeline_ctrl #(
    parameter int CNT_WIDTH    = 16,
    parameter int DMEM_TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_if_stall,
    input  logic                 i_id_stall,
    input  logic                 i_id_flush,
    input  logic                 i_ie_flush,
    input  logic                 i_imem_ready,
    input  logic                 i_dmem_req,
    input  logic                 i_dmem_ack,
    input  logic                 i_cnt_clr,
    output logic                 o_pc_en,
    output logic                 o_ifid_en,
    output logic                 o_idie_en,
    output logic                 o_iem_en,
    output logic                 o_mwb_en,
    output logic                 o_ifid_clr,
    output logic                 o_idie_clr,
    output logic                 o_bus_err,
    output logic [1:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_stall_cnt,
    output logic [CNT_WIDTH-1:0] o_flush_cnt
);

    localparam int WW = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TMO     = WW'(DMEM_TIMEOUT);
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DWAIT = 2'b01,
        ST_DERR  = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
    logic                 pend_flush_q, pend_flush_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    logic resume;
    logic fl_id, fl_ie;
    logic pc_en, ifid_en, idie_en, iem_en, mwb_en;
    logic ifid_clr, idie_clr;
    logic flush_applied;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pend_flush_d  = pend_flush_q;
        resume        = 1'b0;
        fl_id         = 1'b0;
        fl_ie         = 1'b0;
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        idie_en       = 1'b0;
        iem_en        = 1'b0;
        mwb_en        = 1'b0;
        ifid_clr      = 1'b0;
        idie_clr      = 1'b0;
        flush_applied = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (i_dmem_req && !i_dmem_ack) begin
                    state_d      = ST_DWAIT;
                    wait_cnt_d   = WAIT_ONE;
                    // A flush deferred by the memory wait is kept, not dropped.
                    pend_flush_d = i_id_flush | i_ie_flush;
                end else begin
                    resume = 1'b1;
                    fl_id  = i_id_flush;
                    fl_ie  = i_ie_flush;
                end
            end
            ST_DWAIT: begin
                if (i_dmem_ack) begin
                    resume       = 1'b1;
                    fl_id        = i_id_flush | pend_flush_q;
                    fl_ie        = i_ie_flush | pend_flush_q;
                    state_d      = ST_RUN;
                    wait_cnt_d   = '0;
                    pend_flush_d = 1'b0;
                end else begin
                    pend_flush_d = pend_flush_q | i_id_flush | i_ie_flush;
                    if (wait_cnt_q < TMO) begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end else begin
                        state_d    = ST_DERR;
                        wait_cnt_d = '0;
                    end
                end
            end
            ST_DERR: begin
                // Access abandoned: pipeline resumes, replaying any held flush.
                resume       = 1'b1;
                fl_id        = i_id_flush | pend_flush_q;
                fl_ie        = i_ie_flush | pend_flush_q;
                state_d      = ST_RUN;
                wait_cnt_d   = '0;
                pend_flush_d = 1'b0;
            end
            default: begin
                state_d      = ST_RUN;
                wait_cnt_d   = '0;
                pend_flush_d = 1'b0;
            end
        endcase

        if (resume) begin
            pc_en    = fl_id | (~i_if_stall & i_imem_ready);
            ifid_en  = fl_id | ~i_id_stall;
            ifid_clr = fl_id | ~i_imem_ready;
            idie_en  = 1'b1;
            iem_en   = 1'b1;
            mwb_en   = 1'b1;
            idie_clr = fl_ie;
        end
        flush_applied = resume & fl_id;

        if (!i_rst_n) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idie_en  = 1'b0;
            iem_en   = 1'b0;
            mwb_en   = 1'b0;
            ifid_clr = 1'b1;
            idie_clr = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            pend_flush_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            pend_flush_q <= pend_flush_d;
            if (i_cnt_clr) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (!pc_en && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
                    stall_cnt_q <= stall_cnt_q + CNT_ONE;
                end
                if (flush_applied && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
                    flush_cnt_q <= flush_cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign o_pc_en     = pc_en;
    assign o_ifid_en   = ifid_en;
    assign o_idie_en   = idie_en;
    assign o_iem_en    = iem_en;
    assign o_mwb_en    = mwb_en;
    assign o_ifid_clr  = ifid_clr;
    assign o_idie_clr  = idie_clr;
    assign o_bus_err   = (state_q == ST_DERR) & i_rst_n;
    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default-parameter instance (a) and a
// small instance (b: 4-bit counters, timeout 4) share the same stimulus.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst_n, if_stall, id_stall, id_flush, ie_flush;
    logic imem_ready, dmem_req, dmem_ack, cnt_clr;

    logic a_pc, a_ifid, a_idie, a_iem, a_mwb, a_ifid_clr, a_idie_clr, a_berr;
    logic [1:0]  a_state;
    logic [15:0] a_stall, a_flush;
    logic b_pc, b_ifid, b_idie, b_iem, b_mwb, b_ifid_clr, b_idie_clr, b_berr;
    logic [1:0]  b_state;
    logic [3:0]  b_stall, b_flush;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_stall(if_stall), .i_id_stall(id_stall),
        .i_id_flush(id_flush), .i_ie_flush(ie_flush), .i_imem_ready(imem_ready),
        .i_dmem_req(dmem_req), .i_dmem_ack(dmem_ack), .i_cnt_clr(cnt_clr),
        .o_pc_en(a_pc), .o_ifid_en(a_ifid), .o_idie_en(a_idie), .o_iem_en(a_iem),
        .o_mwb_en(a_mwb), .o_ifid_clr(a_ifid_clr), .o_idie_clr(a_idie_clr),
        .o_bus_err(a_berr), .o_state(a_state), .o_stall_cnt(a_stall), .o_flush_cnt(a_flush)
    );

    pipeline_ctrl #(.CNT_WIDTH(4), .DMEM_TIMEOUT(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_stall(if_stall), .i_id_stall(id_stall),
        .i_id_flush(id_flush), .i_ie_flush(ie_flush), .i_imem_ready(imem_ready),
        .i_dmem_req(dmem_req), .i_dmem_ack(dmem_ack), .i_cnt_clr(cnt_clr),
        .o_pc_en(b_pc), .o_ifid_en(b_ifid), .o_idie_en(b_idie), .o_iem_en(b_iem),
        .o_mwb_en(b_mwb), .o_ifid_clr(b_ifid_clr), .o_idie_clr(b_idie_clr),
        .o_bus_err(b_berr), .o_state(b_state), .o_stall_cnt(b_stall), .o_flush_cnt(b_flush)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) begin
            passed++;
            $display("check %-14s got %0h expected %0h ok", tag, obs, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_stall = 0; id_stall = 0; id_flush = 0; ie_flush = 0;
        imem_ready = 1; dmem_req = 0; dmem_ack = 0; cnt_clr = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        dmem_req = 1;
        #1;
        // Reset forces all enables low and both clears high
        check_eq("rst_en", {a_pc, a_ifid, a_idie, a_iem, a_mwb}, 5'b00000);
        check_eq("rst_clr", {a_ifid_clr, a_idie_clr}, 2'b11);
        check_eq("rst_berr", a_berr, 0);
        step();
        check_eq("rst_state", b_state, 2'b00);
        check_eq("rst_cnts", {b_stall, b_flush}, 8'h00);

        idle();
        rst_n = 1;
        #1;
        check_eq("idle_en", {b_pc, b_ifid, b_idie, b_iem, b_mwb}, 5'b11111);
        check_eq("idle_clr", {b_ifid_clr, b_idie_clr}, 2'b00);
        step();
        check_eq("idle_stall", b_stall, 0);

        // Load-use stall
        if_stall = 1; id_stall = 1; ie_flush = 1;
        #1;
        check_eq("lu_en", {b_pc, b_ifid, b_idie, b_iem, b_mwb}, 5'b00111);
        check_eq("lu_clr", {b_ifid_clr, b_idie_clr}, 2'b01);
        step();
        check_eq("lu_stall", b_stall, 1);
        check_eq("lu_flush", b_flush, 0);

        // Taken branch with fetch not ready
        idle();
        id_flush = 1; ie_flush = 1; imem_ready = 0;
        #1;
        check_eq("br_en", {b_pc, b_ifid, b_idie, b_iem, b_mwb}, 5'b11111);
        check_eq("br_clr", {b_ifid_clr, b_idie_clr}, 2'b11);
        step();
        check_eq("br_flush", b_flush, 1);
        check_eq("br_stall", b_stall, 1);

        // Data-memory wait, fetch also not ready so the ack cycle holds pc
        idle();
        imem_ready = 0; dmem_req = 1;
        #1;
        check_eq("dw_req_en", {b_pc, b_ifid, b_idie, b_iem, b_mwb}, 5'b00000);
        check_eq("dw_req_clr", {b_ifid_clr, b_idie_clr}, 2'b00);
        step();
        check_eq("dw_st1", b_state, 2'b01);
        check_eq("dw_en1", {b_pc, b_ifid, b_idie, b_iem, b_mwb}, 5'b00000);
        step();
        check_eq("dw_st2", b_state, 2'b01);
        step();
        check_eq("dw_st3", b_state, 2'b01);
        dmem_ack = 1;
        #1;
        check_eq("dw_ack_en", {b_pc, b_ifid, b_idie, b_iem, b_mwb}, 5'b01111);
        check_eq("dw_ack_clr", {b_ifid_clr, b_idie_clr}, 2'b10);
        step();
        idle();
        check_eq("dw_run", b_state, 2'b00);
        check_eq("dw_stall", b_stall, 5);
        check_eq("dw_stall_a", a_stall, 5);

        // Flush pulse during a long wait on instance a (timeout 64)
        do_reset();
        dmem_req = 1;
        step();
        check_eq("fw_st", a_state, 2'b01);
        step();
        id_flush = 1;
        #1;
        check_eq("fw_pulse_en", {a_pc, a_ifid, a_idie, a_iem, a_mwb}, 5'b00000);
        step();
        id_flush = 0;
        step();
        step();
        dmem_ack = 1;
        #1;
        check_eq("fw_ack_pc", a_pc, 1);
        check_eq("fw_ack_clr", {a_ifid_clr, a_idie_clr}, 2'b11);
        check_eq("fw_ack_en", {a_pc, a_ifid, a_idie, a_iem, a_mwb}, 5'b11111);
        step();
        idle();
        check_eq("fw_run", a_state, 2'b00);
        check_eq("fw_flush", a_flush, 1);
        check_eq("fw_stall", a_stall, 5);
        check_eq("fw_noclr", {a_ifid_clr, a_idie_clr}, 2'b00);

        // Timeout on instance b: ack never arrives
        do_reset();
        dmem_req = 1;
        step();
        check_eq("to_w1", b_state, 2'b01);
        step();
        check_eq("to_w2", b_state, 2'b01);
        step();
        check_eq("to_w3", b_state, 2'b01);
        step();
        check_eq("to_w4", b_state, 2'b01);
        check_eq("to_w4_berr", b_berr, 0);
        step();
        dmem_req = 0;
        #1;
        check_eq("to_derr", b_state, 2'b10);
        check_eq("to_berr", b_berr, 1);
        check_eq("to_derr_en", {b_pc, b_ifid, b_idie, b_iem, b_mwb}, 5'b11111);
        step();
        check_eq("to_run", b_state, 2'b00);
        check_eq("to_berr_off", b_berr, 0);
        check_eq("to_stall", b_stall, 5);

        // Reset during a wait abandons the access
        idle();
        dmem_req = 1;
        step();
        check_eq("rw_st", b_state, 2'b01);
        rst_n = 0;
        #1;
        check_eq("rw_en", {b_pc, b_ifid, b_idie, b_iem, b_mwb}, 5'b00000);
        check_eq("rw_clr", {b_ifid_clr, b_idie_clr}, 2'b11);
        step();
        idle();
        rst_n = 1;
        check_eq("rw_run", b_state, 2'b00);
        step();
        check_eq("rw_run2", b_state, 2'b00);
        check_eq("rw_berr", b_berr, 0);

        // Saturation and clear
        do_reset();
        imem_ready = 0;
        for (int i = 0; i < 20; i++) step();
        check_eq("sat_b", b_stall, 15);
        check_eq("sat_a", a_stall, 20);
        cnt_clr = 1;
        step();
        check_eq("clr_b", b_stall, 0);
        check_eq("clr_a", a_stall, 0);
        cnt_clr = 0;
        step();
        check_eq("post_clr_b", b_stall, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
